// File: rtl/branch_predictor_unit.sv
// Dynamic branch predictor: direct-mapped BTB with saturating direction counters
// and a circular return-address stack, looked up combinationally and trained from EX.
module branch_predictor_unit #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned TAG_W     = 10,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_pc_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i,
  input  logic [1:0]      upd_kind_i,
  input  logic            upd_mispred_i,
  output logic [31:0]     lookups_o,
  output logic [31:0]     mispreds_o
);

  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned PTR_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned RCNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [CNT_W-1:0]  CNT_WT   = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_WNT  = CNT_WT - CNT_W'(1);
  localparam logic [RCNT_W-1:0] RAS_FULL = RCNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(RAS_DEPTH - 1);

  typedef enum logic [1:0] {
    K_COND = 2'b00,
    K_JUMP = 2'b01,
    K_CALL = 2'b10,
    K_RET  = 2'b11
  } kind_e;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  kind_e              kind_q   [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];

  logic [XLEN-1:0]    ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]   ras_ptr_q, ras_ptr_d;
  logic [RCNT_W-1:0]  ras_cnt_q, ras_cnt_d;
  logic [PTR_W-1:0]   ptr_inc, ptr_dec;
  logic               ras_push;

  logic [31:0]        lookups_q, lookups_d;
  logic [31:0]        mispreds_q, mispreds_d;

  logic [IDX_W-1:0]   l_idx, u_idx;
  logic [TAG_W-1:0]   l_tag, u_tag;
  logic [XLEN-1:0]    l_seq;
  logic               u_hit, u_alloc, u_train;
  kind_e              u_kind;
  logic [CNT_W-1:0]   u_cnt_d;

  assign l_idx  = pc_i[IDX_W+1:2];
  assign l_tag  = pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign l_seq  = pc_i + XLEN'(4);
  assign u_idx  = upd_pc_i[IDX_W+1:2];
  assign u_tag  = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign u_kind = kind_e'(upd_kind_i);

  // ras_ptr_q is the next free slot, so the top of stack sits one below it
  assign ptr_inc = (ras_ptr_q == PTR_LAST) ? '0 : ras_ptr_q + PTR_W'(1);
  assign ptr_dec = (ras_ptr_q == '0) ? PTR_LAST : ras_ptr_q - PTR_W'(1);

  always_comb begin
    pred_hit_o   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    pred_taken_o = 1'b0;
    pred_pc_o    = l_seq;
    if (pred_hit_o) begin
      unique case (kind_q[l_idx])
        K_COND: begin
          if (cnt_q[l_idx][CNT_W-1]) begin
            pred_taken_o = 1'b1;
            pred_pc_o    = target_q[l_idx];
          end
        end
        K_JUMP, K_CALL: begin
          pred_taken_o = 1'b1;
          pred_pc_o    = target_q[l_idx];
        end
        K_RET: begin
          pred_taken_o = 1'b1;
          pred_pc_o    = (ras_cnt_q != '0) ? ras_q[ptr_dec] : target_q[l_idx];
        end
        default: ;
      endcase
    end
  end

  assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_alloc = upd_valid_i && !u_hit && ((u_kind != K_COND) || upd_taken_i);
  assign u_train = upd_valid_i && u_hit;

  always_comb begin
    u_cnt_d = cnt_q[u_idx];
    if (upd_taken_i) begin
      if (cnt_q[u_idx] != '1) u_cnt_d = cnt_q[u_idx] + CNT_W'(1);
    end else begin
      if (cnt_q[u_idx] != '0) u_cnt_d = cnt_q[u_idx] - CNT_W'(1);
    end
  end

  always_comb begin
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_push  = 1'b0;
    if (upd_valid_i && (u_kind == K_CALL)) begin
      // full stack keeps its count: the push lands on the oldest slot
      ras_push  = 1'b1;
      ras_ptr_d = ptr_inc;
      if (ras_cnt_q != RAS_FULL) ras_cnt_d = ras_cnt_q + RCNT_W'(1);
    end else if (upd_valid_i && (u_kind == K_RET) && (ras_cnt_q != '0)) begin
      ras_ptr_d = ptr_dec;
      ras_cnt_d = ras_cnt_q - RCNT_W'(1);
    end
  end

  always_comb begin
    lookups_d  = pred_hit_o ? lookups_q + 32'd1 : lookups_q;
    mispreds_d = (upd_valid_i && upd_mispred_i) ? mispreds_q + 32'd1 : mispreds_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        cnt_q[i[IDX_W-1:0]] <= CNT_WNT;
      end
    end else if (u_alloc) begin
      valid_q[u_idx] <= 1'b1;
      cnt_q[u_idx]   <= CNT_WT;
    end else if (u_train) begin
      cnt_q[u_idx]   <= u_cnt_d;
    end
  end

  // Payload arrays are not reset; valid_q and ras_cnt_q guard every read of them
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (u_alloc) tag_q[u_idx] <= u_tag;
      if (u_alloc || u_train) kind_q[u_idx] <= u_kind;
      if (u_alloc || (u_train && upd_taken_i)) target_q[u_idx] <= upd_target_i;
      if (ras_push) ras_q[ras_ptr_q] <= upd_pc_i + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ras_ptr_q  <= '0;
      ras_cnt_q  <= '0;
      lookups_q  <= '0;
      mispreds_q <= '0;
    end else begin
      ras_ptr_q  <= ras_ptr_d;
      ras_cnt_q  <= ras_cnt_d;
      lookups_q  <= lookups_d;
      mispreds_q <= mispreds_d;
    end
  end

  assign lookups_o  = lookups_q;
  assign mispreds_o = mispreds_q;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Bench for branch_predictor_unit: directed scenarios plus randomized traffic
// compared against a table/queue model of the predictor.
module tb_branch_predictor_unit;
  localparam int unsigned XLEN      = 64;
  localparam int unsigned ENTRIES   = 16;
  localparam int unsigned TAG_W     = 10;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned RAS_DEPTH = 4;
  localparam int unsigned IDX_W     = $clog2(ENTRIES);

  logic            clk = 1'b0;
  logic            rst_i;
  logic [XLEN-1:0] pc_i;
  logic            pred_hit_o, pred_taken_o;
  logic [XLEN-1:0] pred_pc_o;
  logic            upd_valid_i;
  logic [XLEN-1:0] upd_pc_i, upd_target_i;
  logic            upd_taken_i;
  logic [1:0]      upd_kind_i;
  logic            upd_mispred_i;
  logic [31:0]     lookups_o, mispreds_o;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  branch_predictor_unit #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i),
    .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_pc_o(pred_pc_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i),
    .upd_taken_i(upd_taken_i), .upd_kind_i(upd_kind_i), .upd_mispred_i(upd_mispred_i),
    .lookups_o(lookups_o), .mispreds_o(mispreds_o)
  );

  // Reference model: one record per table slot, RAS as a bounded queue
  bit              m_valid [ENTRIES];
  longint unsigned m_tag   [ENTRIES];
  logic [XLEN-1:0] m_tgt   [ENTRIES];
  int              m_kind  [ENTRIES];
  int              m_cnt   [ENTRIES];
  logic [XLEN-1:0] m_ras   [$];
  int unsigned     m_look, m_mis;

  function automatic int midx(input logic [XLEN-1:0] a);
    return int'((a >> 2) % ENTRIES);
  endfunction

  function automatic longint unsigned mtag(input logic [XLEN-1:0] a);
    return longint'((a >> (2 + IDX_W)) % (64'd1 << TAG_W));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 2 ** (CNT_W - 1) - 1;
    end
    m_ras.delete();
    m_look = 0;
    m_mis  = 0;
  endfunction

  function automatic void predict(input logic [XLEN-1:0] a, output logic h, output logic t,
                                  output logic [XLEN-1:0] npc);
    int i;
    i   = midx(a);
    h   = m_valid[i] && (m_tag[i] == mtag(a));
    t   = 1'b0;
    npc = a + 4;
    if (h) begin
      if (m_kind[i] == 0) begin
        if (m_cnt[i] >= 2 ** (CNT_W - 1)) begin
          t = 1'b1;
          npc = m_tgt[i];
        end
      end else if (m_kind[i] == 3) begin
        t = 1'b1;
        npc = (m_ras.size() > 0) ? m_ras[$] : m_tgt[i];
      end else begin
        t = 1'b1;
        npc = m_tgt[i];
      end
    end
  endfunction

  task automatic drive(input logic r, input logic [XLEN-1:0] p, input logic uv,
                       input logic [XLEN-1:0] upc, input logic [XLEN-1:0] utgt,
                       input logic utk, input logic [1:0] uk, input logic um);
    @(negedge clk);
    rst_i = r; pc_i = p; upd_valid_i = uv; upd_pc_i = upc; upd_target_i = utgt;
    upd_taken_i = utk; upd_kind_i = uk; upd_mispred_i = um;
    #1;
  endtask

  // Advance the model by the current input set, then let the DUT take its edge
  task automatic commit();
    logic h, t;
    logic [XLEN-1:0] npc;
    int i;
    if (!rst_i) begin
      model_reset();
    end else begin
      predict(pc_i, h, t, npc);
      if (h) m_look++;
      if (upd_valid_i && upd_mispred_i) m_mis++;
      if (upd_valid_i) begin
        i = midx(upd_pc_i);
        if (m_valid[i] && m_tag[i] == mtag(upd_pc_i)) begin
          m_kind[i] = int'(upd_kind_i);
          if (upd_taken_i) begin
            m_cnt[i] = (m_cnt[i] < 2 ** CNT_W - 1) ? m_cnt[i] + 1 : m_cnt[i];
            m_tgt[i] = upd_target_i;
          end else begin
            m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
          end
        end else if (upd_kind_i != 2'b00 || upd_taken_i) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = mtag(upd_pc_i);
          m_tgt[i]   = upd_target_i;
          m_kind[i]  = int'(upd_kind_i);
          m_cnt[i]   = 2 ** (CNT_W - 1);
        end
        if (upd_kind_i == 2'b10) begin
          m_ras.push_back(upd_pc_i + 4);
          if (m_ras.size() > int'(RAS_DEPTH)) void'(m_ras.pop_front());
        end else if (upd_kind_i == 2'b11 && m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic [XLEN-1:0] p);
    drive(1'b1, p, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic upd(input logic [XLEN-1:0] upc, input logic [XLEN-1:0] utgt,
                     input logic utk, input logic [1:0] uk);
    drive(1'b1, 64'h900, 1'b1, upc, utgt, utk, uk, 1'b0);
    commit();
  endtask

  task automatic test_reset();
    drive(1'b0, 64'h8000_0000, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
    commit();
    idle(64'h8000_0000);
    checks++;
    if (pred_hit_o !== 1'b0 || pred_taken_o !== 1'b0 || pred_pc_o !== 64'h8000_0004) begin
      fails++;
      $display("FAIL reset_pred got hit=%b taken=%b pc=%h want 0 0 80000004",
               pred_hit_o, pred_taken_o, pred_pc_o);
    end
    checks++;
    if (lookups_o !== 32'd0 || mispreds_o !== 32'd0) begin
      fails++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", lookups_o, mispreds_o);
    end
    commit();
  endtask

  task automatic test_cond_learn();
    upd(64'h100, 64'h40, 1'b1, 2'b00);
    upd(64'h100, 64'h40, 1'b1, 2'b00);
    idle(64'h100);
    checks++;
    if (pred_hit_o !== 1'b1 || pred_taken_o !== 1'b1 || pred_pc_o !== 64'h40) begin
      fails++;
      $display("FAIL cond_taken got hit=%b taken=%b pc=%h want 1 1 40",
               pred_hit_o, pred_taken_o, pred_pc_o);
    end
    commit();
    for (int k = 0; k < 3; k++) upd(64'h100, 64'h40, 1'b0, 2'b00);
    idle(64'h100);
    checks++;
    if (pred_hit_o !== 1'b1 || pred_taken_o !== 1'b0 || pred_pc_o !== 64'h104) begin
      fails++;
      $display("FAIL cond_not_taken got hit=%b taken=%b pc=%h want 1 0 104",
               pred_hit_o, pred_taken_o, pred_pc_o);
    end
    checks++;
    if (lookups_o !== m_look) begin
      fails++;
      $display("FAIL cond_lookups got %0d want %0d", lookups_o, m_look);
    end
    commit();
  endtask

  task automatic test_alias();
    upd(64'h100 + 4 * ENTRIES, 64'h80, 1'b1, 2'b01);
    idle(64'h100);
    checks++;
    if (pred_hit_o !== 1'b0 || pred_pc_o !== 64'h104) begin
      fails++;
      $display("FAIL alias_evicted got hit=%b pc=%h want 0 104", pred_hit_o, pred_pc_o);
    end
    commit();
    idle(64'h100 + 4 * ENTRIES);
    checks++;
    if (pred_hit_o !== 1'b1 || pred_taken_o !== 1'b1 || pred_pc_o !== 64'h80) begin
      fails++;
      $display("FAIL alias_new got hit=%b taken=%b pc=%h want 1 1 80",
               pred_hit_o, pred_taken_o, pred_pc_o);
    end
    commit();
  endtask

  task automatic test_ras();
    logic [XLEN-1:0] want [4] = '{64'h600, 64'h304, 64'h204, 64'h280};
    upd(64'h504, 64'h600, 1'b1, 2'b11);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        upd(64'h200, 64'h1000, 1'b1, 2'b10);
        upd(64'h300, 64'h1000, 1'b1, 2'b10);
      end
      if (k == 2) upd(64'h504, 64'h304, 1'b1, 2'b11);
      if (k == 3) upd(64'h504, 64'h280, 1'b1, 2'b11);
      idle(64'h504);
      checks++;
      if (pred_hit_o !== 1'b1 || pred_taken_o !== 1'b1 || pred_pc_o !== want[k]) begin
        fails++;
        $display("FAIL ras_step%0d got hit=%b taken=%b pc=%h want 1 1 %h",
                 k, pred_hit_o, pred_taken_o, pred_pc_o, want[k]);
      end
      commit();
    end
  endtask

  task automatic test_ras_overflow();
    logic [XLEN-1:0] want [8] = '{64'h44, 64'h34, 64'h24, 64'h14, 64'hABC0, 64'hABC0,
                                  64'h54, 64'hABC0};
    for (int c = 0; c <= int'(RAS_DEPTH); c++) upd(64'(c * 16), 64'h1000, 1'b1, 2'b10);
    for (int k = 0; k < 8; k++) begin
      idle(64'h504);
      checks++;
      if (pred_pc_o !== want[k]) begin
        fails++;
        $display("FAIL ras_overflow%0d got pc=%h want %h", k, pred_pc_o, want[k]);
      end
      commit();
      if (k == 5) upd(64'h50, 64'h1000, 1'b1, 2'b10);
      else upd(64'h504, 64'hABC0, 1'b1, 2'b11);
    end
  endtask

  task automatic test_same_cycle_and_reset();
    upd(64'h188, 64'h1000, 1'b1, 2'b01);
    drive(1'b1, 64'h188, 1'b1, 64'h188, 64'h2000, 1'b1, 2'b01, 1'b0);
    checks++;
    if (pred_pc_o !== 64'h1000) begin
      fails++;
      $display("FAIL same_cycle_old got pc=%h want 1000", pred_pc_o);
    end
    commit();
    idle(64'h188);
    checks++;
    if (pred_pc_o !== 64'h2000) begin
      fails++;
      $display("FAIL same_cycle_new got pc=%h want 2000", pred_pc_o);
    end
    commit();
    drive(1'b0, 64'h188, 1'b1, 64'h3C8, 64'h3000, 1'b1, 2'b01, 1'b1);
    commit();
    idle(64'h3C8);
    checks++;
    if (pred_hit_o !== 1'b0 || pred_pc_o !== 64'h3CC || lookups_o !== 32'd0 ||
        mispreds_o !== 32'd0) begin
      fails++;
      $display("FAIL reset_wins got hit=%b pc=%h cnt=%0d/%0d want 0 3cc 0/0",
               pred_hit_o, pred_pc_o, lookups_o, mispreds_o);
    end
    commit();
    idle(64'h188);
    checks++;
    if (pred_hit_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_clears got hit=%b want 0", pred_hit_o);
    end
    commit();
  endtask

  task automatic test_random();
    logic            r, uv, utk, um, eh, et;
    logic [1:0]      uk;
    logic [XLEN-1:0] p, upc, utgt, epc;
    for (int n = 0; n < 600; n++) begin
      r    = ($urandom_range(0, 79) != 0);
      p    = 64'h1000 + 4 * $urandom_range(0, 47);
      uv   = ($urandom_range(0, 3) != 0);
      upc  = 64'h1000 + 4 * $urandom_range(0, 47);
      uk   = 2'($urandom_range(0, 3));
      utk  = (uk != 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
      utgt = 64'h2000 + 4 * $urandom_range(0, 255);
      um   = 1'($urandom_range(0, 1));
      drive(r, p, uv, upc, utgt, utk, uk, um);
      predict(p, eh, et, epc);
      checks++;
      if (pred_hit_o !== eh || pred_taken_o !== et || pred_pc_o !== epc) begin
        fails++;
        $display("FAIL rand_pred%0d pc=%h got %b/%b/%h want %b/%b/%h",
                 n, p, pred_hit_o, pred_taken_o, pred_pc_o, eh, et, epc);
      end
      checks++;
      if (lookups_o !== m_look || mispreds_o !== m_mis) begin
        fails++;
        $display("FAIL rand_counters%0d got %0d/%0d want %0d/%0d",
                 n, lookups_o, mispreds_o, m_look, m_mis);
      end
      commit();
    end
  endtask

  initial begin
    rst_i = 1'b0; pc_i = '0; upd_valid_i = 1'b0; upd_pc_i = '0; upd_target_i = '0;
    upd_taken_i = 1'b0; upd_kind_i = 2'b00; upd_mispred_i = 1'b0;
    model_reset();
    test_reset();
    test_cond_learn();
    test_alias();
    test_ras();
    test_ras_overflow();
    test_same_cycle_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
